// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back arbiter and RAW scoreboard for the 32x32 register file.
// Ports:
//   clk, reset          - clock, async active-high reset
//   a_we/a_wa/a_wd/a_pc - in-order WB stage write (port A, always wins)
//   b_valid/b_wa/b_wd/b_pc, b_ready - long-latency result handshake (port B)
//   iss_valid/iss_wa    - port-B issue, marks destination busy
//   ra1/ra2, stall      - decode sources and decode hold request
//   we3/wa3/wd3/pc      - registered register-file write port
//   err                 - sticky protocol-violation flag
// Optional: define RF_ARB_TRACE_EN to print each committed write.
module rf_wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_we,
    input  logic [4:0]  a_wa,
    input  logic [31:0] a_wd,
    input  logic [31:0] a_pc,
    input  logic        b_valid,
    input  logic [4:0]  b_wa,
    input  logic [31:0] b_wd,
    input  logic [31:0] b_pc,
    output logic        b_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_wa,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        stall,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic [31:0] pc,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] busy;
    logic [31:0] busy_nxt;
    logic        a_win;
    logic        b_clr;
    logic        iss_set;
    logic        err_set;
    logic [3:0]  cnt_inc;

    // Writes to $0 are discarded, so they never block port B.
    assign a_win   = a_we && (a_wa != 5'd0);
    assign b_ready = b_valid && !a_win;
    assign b_clr   = b_ready && (b_wa != 5'd0);
    assign iss_set = iss_valid && (iss_wa != 5'd0);
    assign cnt_inc = cnt + 4'd1;

    assign stall = (ra1 != 5'd0 && busy[ra1])
                 | (ra2 != 5'd0 && busy[ra2])
                 | (state == FORCE);

    // Clear first so a same-cycle re-issue keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (b_clr) begin
            busy_nxt[b_wa] = 1'b0;
        end
        if (iss_set) begin
            busy_nxt[iss_wa] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        err_set = 1'b0;
        if (iss_set && busy[iss_wa] && !(b_clr && b_wa == iss_wa)) begin
            err_set = 1'b1;
        end
        if (a_win && busy[a_wa]) begin
            err_set = 1'b1;
        end
        if (a_win && state == FORCE) begin
            err_set = 1'b1;
        end
        if (b_valid && b_wa != 5'd0 && !busy[b_wa]) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // cnt counts every ungranted b_valid cycle, including the one that
    // leaves IDLE, so FORCE follows exactly STARVE_MAX waiting cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (!b_valid || b_ready) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                IDLE, WAIT: begin
                    cnt <= cnt_inc;
                    if (cnt_inc >= 4'(STARVE_MAX)) begin
                        state <= FORCE;
                    end else begin
                        state <= WAIT;
                    end
                end
                FORCE: begin
                    state <= FORCE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3 <= 1'b0;
            wa3 <= 5'd0;
            wd3 <= 32'd0;
            pc  <= 32'd0;
        end else begin
            unique case (1'b1)
                a_win: begin
                    we3 <= 1'b1;
                    wa3 <= a_wa;
                    wd3 <= a_wd;
                    pc  <= a_pc;
                end
                b_ready: begin
                    // A $0 result completes the handshake but never writes.
                    we3 <= (b_wa != 5'd0);
                    wa3 <= b_wa;
                    wd3 <= b_wd;
                    pc  <= b_pc;
                end
                default: begin
                    we3 <= 1'b0;
                end
            endcase
        end
    end

`ifdef RF_ARB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && we3) begin
            $display("%d@%h: $%d <= %h", $time, pc, wa3, wd3);
        end
    end
`endif

endmodule
